noc_local_interface: RTL

//  Network interface between one processing core and its router's Local port (port 0).
//  TX side packetises core messages and drives the router's local input handshake.
//  RX side accepts packets from the router's local output into a FIFO and returns them to the core.
//  It is the upstream sender and the downstream receiver for the router's local req/gnt/full links.

---
 rtl/noc_local_if.sv | 42 ++++
 rtl/noc_local_interface.sv | 134 +++++++++++++
 2 files changed

// File: rtl/noc_local_if.sv
// Core/router-facing signal bundle of the local network interface.
// slave: the interface block itself; master: the core/router environment around it.
interface noc_local_if #(
    parameter int unsigned datawidth   = 25,
    parameter int unsigned packetwidth = 55
);
    // TX: core -> interface -> router local input
    logic                   coreTxValid;
    logic                   coreTxReady;
    logic [5:0]             coreTxDest;
    logic [datawidth-1:0]   coreTxData;
    logic                   txReqDnStr;
    logic                   txGntDnStr;
    logic                   txDnStrFull;
    logic [packetwidth-1:0] txPacketOut;

    // RX: router local output -> interface -> core
    logic                   rxReqUpStr;
    logic                   rxGntUpStr;
    logic                   rxUpStrFull;
    logic [packetwidth-1:0] rxPacketIn;
    logic                   coreRxValid;
    logic                   coreRxReady;
    logic [5:0]             coreRxSrc;
    logic [datawidth-1:0]   coreRxData;
    logic [9:0]             coreRxLatency;
    logic [7:0]             misrouteCount;

    modport slave (
        input  coreTxValid, coreTxDest, coreTxData, txGntDnStr, txDnStrFull,
               rxReqUpStr, rxPacketIn, coreRxReady,
        output coreTxReady, txReqDnStr, txPacketOut, rxGntUpStr, rxUpStrFull,
               coreRxValid, coreRxSrc, coreRxData, coreRxLatency, misrouteCount
    );

    modport master (
        output coreTxValid, coreTxDest, coreTxData, txGntDnStr, txDnStrFull,
               rxReqUpStr, rxPacketIn, coreRxReady,
        input  coreTxReady, txReqDnStr, txPacketOut, rxGntUpStr, rxUpStrFull,
               coreRxValid, coreRxSrc, coreRxData, coreRxLatency, misrouteCount
    );
endinterface

// File: rtl/noc_local_interface.sv
// Network interface between a core and its router's local port: TX packetiser
// with a two-state req/gnt sender, RX FIFO receiver with latency and misroute stats.
module noc_local_interface #(
    parameter logic [5:0]  routerID    = 6'b000_000,
    parameter int unsigned packetwidth = 55,
    parameter int unsigned datawidth   = 25,
    parameter int unsigned rxAddrWidth = 2
) (
    input  logic      clk,
    input  logic      reset,
    noc_local_if.slave bus
);
    localparam int unsigned DEPTH    = 1 << rxAddrWidth;
    localparam int unsigned CNT_W    = rxAddrWidth + 1;
    localparam int unsigned DEST_LSB = packetwidth - 6;
    localparam int unsigned SRC_LSB  = packetwidth - 12;
    localparam int unsigned SEQ_LSB  = datawidth + 10;
    localparam int unsigned TS_LSB   = datawidth;

    typedef enum logic {IDLE, SEND} tx_state_t;

    tx_state_t              tx_state;
    tx_state_t              tx_next;
    logic                   tx_ready;
    logic                   tx_req;
    logic                   tx_load;
    logic [7:0]             seq;
    logic [9:0]             ts_cnt;
    logic [packetwidth-1:0] tx_packet;

    logic [packetwidth-1:0] mem [DEPTH];
    logic [rxAddrWidth-1:0] wr_ptr;
    logic [rxAddrWidth-1:0] rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [7:0]             misroute;
    logic                   rx_full;
    logic                   rx_valid;
    logic                   push;
    logic                   pop;
    logic [packetwidth-1:0] head;
    logic                   unused_head_seq;

    // TX next-state and handshake outputs; everything held low during reset
    always_comb begin
        tx_next  = tx_state;
        tx_ready = 1'b0;
        tx_req   = 1'b0;
        tx_load  = 1'b0;
        if (!reset) begin
            case (tx_state)
                IDLE: begin
                    tx_ready = 1'b1;
                    if (bus.coreTxValid) begin
                        tx_load = 1'b1;
                        tx_next = SEND;
                    end
                end
                SEND: begin
                    tx_req = !bus.txDnStrFull;
                    if (tx_req && bus.txGntDnStr) begin
                        tx_next = IDLE;
                    end
                end
            endcase
        end
    end

    // TX state, sequence number, timestamp counter and packet register
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= IDLE;
            seq       <= 8'd0;
            ts_cnt    <= 10'd0;
            tx_packet <= '0;
        end else begin
            tx_state <= tx_next;
            ts_cnt   <= ts_cnt + 10'd1;
            if (tx_load) begin
                tx_packet <= {bus.coreTxDest, routerID, seq, ts_cnt, bus.coreTxData};
                seq       <= seq + 8'd1;
            end
        end
    end

    assign bus.coreTxReady = tx_ready;
    assign bus.txReqDnStr  = tx_req;
    assign bus.txPacketOut = tx_packet;

    // RX handshake: full blocks the grant even if a pop happens this cycle
    assign rx_full  = (count == CNT_W'(DEPTH));
    assign rx_valid = (count != '0);
    assign push     = !reset && bus.rxReqUpStr && !rx_full;
    assign pop      = !reset && rx_valid && bus.coreRxReady;
    assign head     = mem[rd_ptr];

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rxPacketIn;
        end
    end

    // RX pointers, occupancy and saturating misroute counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misroute <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && (bus.rxPacketIn[DEST_LSB +: 6] != routerID) && (misroute != 8'hFF)) begin
                misroute <= misroute + 8'd1;
            end
        end
    end

    // Sequence number is not reported to the core
    assign unused_head_seq = ^head[SEQ_LSB +: 8];

    assign bus.rxGntUpStr    = push;
    assign bus.rxUpStrFull   = !reset && rx_full;
    assign bus.coreRxValid   = !reset && rx_valid;
    assign bus.coreRxSrc     = reset ? 6'd0 : head[SRC_LSB +: 6];
    assign bus.coreRxData    = reset ? '0 : head[datawidth-1:0];
    assign bus.coreRxLatency = reset ? 10'd0 : ts_cnt - head[TS_LSB +: 10];
    assign bus.misrouteCount = misroute;
endmodule
